// File: rtl/gmii_rx_nibble_pack.sv
`default_nettype none
// ============================================================================
// Module   : gmii_rx_nibble_pack
// Purpose  : Receive-side nibble packer. In MII (10/100) mode it assembles
//            4-bit receive nibbles into bytes aligned to the start frame
//            delimiter. In 1000M mode it is a one-register pipeline.
// Ports    : clk, rst (async, active-high)
//            mii_select     1 = nibble mode, 0 = byte mode (sampled in IDLE)
//            in_clk_en      input sample strobe
//            in_rxd/in_rx_dv/in_rx_er   GMII-style receive stream
//            out_clk_en     one-cycle byte strobe to the MAC
//            out_rxd/out_rx_dv/out_rx_er  packed byte, held between strobes
//            odd_nibble     pulse: frame ended with an unpaired nibble
//            align_err      pulse: bad preamble or bad first nibble
//            frame_count    saturating count of frames that received an SFD
//            align_err_count saturating count of align_err events
// Config   : GMII_RX_PACK_STATS_EN builds the statistics counters; when it is
//            undefined both counter ports are constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module gmii_rx_nibble_pack #(
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mii_select,
    input  logic                  in_clk_en,
    input  logic [7:0]            in_rxd,
    input  logic                  in_rx_dv,
    input  logic                  in_rx_er,
    output logic                  out_clk_en,
    output logic [7:0]            out_rxd,
    output logic                  out_rx_dv,
    output logic                  out_rx_er,
    output logic                  odd_nibble,
    output logic                  align_err,
    output logic [STAT_WIDTH-1:0] frame_count,
    output logic [STAT_WIDTH-1:0] align_err_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_DATA_LO = 3'd2,
        S_DATA_HI = 3'd3,
        S_DISCARD = 3'd4,
        S_BYTE    = 3'd5
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_mode,   w_mode_nxt;     // latched mii_select
    logic [3:0] r_nib,    w_nib_nxt;      // stored (low) nibble
    logic       r_pend,   w_pend_nxt;     // one preamble nibble waiting for its pair
    logic       r_lo_er,  w_lo_er_nxt;    // er of the stored low data nibble
    logic       r_er_acc, w_er_acc_nxt;   // preamble errors not yet reported
    logic       r_clk_en, w_clk_en_nxt;
    logic [7:0] r_rxd,    w_rxd_nxt;
    logic       r_dv,     w_dv_nxt;
    logic       r_er,     w_er_nxt;
    logic       r_odd,    w_odd_nxt;
    logic       r_align,  w_align_nxt;

    logic [3:0] w_nibble;
    logic       w_mode_eff;

    assign w_nibble   = in_rxd[3:0];
    // In IDLE the mode for this very sample is the live select; once a frame
    // has started the latched copy is used so mid-frame changes are ignored.
    assign w_mode_eff = (r_state == S_IDLE) ? mii_select : r_mode;

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_nib_nxt    = r_nib;
        w_pend_nxt   = r_pend;
        w_lo_er_nxt  = r_lo_er;
        w_er_acc_nxt = r_er_acc;
        w_clk_en_nxt = 1'b0;
        w_rxd_nxt    = r_rxd;
        w_dv_nxt     = r_dv;
        w_er_nxt     = r_er;
        w_odd_nxt    = 1'b0;
        w_align_nxt  = 1'b0;

        if (in_clk_en) begin
            if (r_state == S_IDLE) begin
                w_mode_nxt = mii_select;
            end

            if (!w_mode_eff) begin
                // Byte mode: straight register stage; S_BYTE only tracks the
                // frame so the mode latch is not reloaded mid-frame.
                w_clk_en_nxt = 1'b1;
                w_rxd_nxt    = in_rxd;
                w_dv_nxt     = in_rx_dv;
                w_er_nxt     = in_rx_er;
                w_state_nxt  = in_rx_dv ? S_BYTE : S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (in_rx_dv) begin
                            if (w_nibble == 4'h5) begin
                                w_state_nxt  = S_PRE;
                                w_nib_nxt    = 4'h5;
                                w_pend_nxt   = 1'b1;
                                w_er_acc_nxt = in_rx_er;
                            end else begin
                                w_state_nxt  = S_DISCARD;
                                w_align_nxt  = 1'b1;
                                w_dv_nxt     = 1'b0;
                            end
                        end
                    end
                    S_PRE: begin
                        if (!in_rx_dv) begin
                            w_state_nxt  = S_IDLE;
                            w_clk_en_nxt = 1'b1;
                            w_rxd_nxt    = 8'h00;
                            w_dv_nxt     = 1'b0;
                            w_er_nxt     = 1'b0;
                            w_pend_nxt   = 1'b0;
                            w_er_acc_nxt = 1'b0;
                        end else if (w_nibble == 4'h5) begin
                            if (r_pend) begin
                                w_clk_en_nxt = 1'b1;
                                w_rxd_nxt    = 8'h55;
                                w_dv_nxt     = 1'b1;
                                w_er_nxt     = r_er_acc | in_rx_er;
                                w_er_acc_nxt = 1'b0;
                                w_pend_nxt   = 1'b0;
                            end else begin
                                w_pend_nxt   = 1'b1;
                                w_er_acc_nxt = r_er_acc | in_rx_er;
                            end
                        end else if (w_nibble == 4'hD) begin
                            // SFD realigns: any pending preamble nibble is
                            // absorbed so data pairing starts fresh.
                            w_state_nxt  = S_DATA_LO;
                            w_clk_en_nxt = 1'b1;
                            w_rxd_nxt    = 8'hD5;
                            w_dv_nxt     = 1'b1;
                            w_er_nxt     = r_er_acc | in_rx_er;
                            w_er_acc_nxt = 1'b0;
                            w_pend_nxt   = 1'b0;
                        end else begin
                            // Aborted frame: no closing strobe follows, so
                            // drop the held valid to avoid a stuck frame.
                            w_state_nxt  = S_DISCARD;
                            w_align_nxt  = 1'b1;
                            w_dv_nxt     = 1'b0;
                            w_pend_nxt   = 1'b0;
                            w_er_acc_nxt = 1'b0;
                        end
                    end
                    S_DATA_LO: begin
                        if (!in_rx_dv) begin
                            w_state_nxt  = S_IDLE;
                            w_clk_en_nxt = 1'b1;
                            w_rxd_nxt    = 8'h00;
                            w_dv_nxt     = 1'b0;
                            w_er_nxt     = 1'b0;
                        end else begin
                            w_state_nxt  = S_DATA_HI;
                            w_nib_nxt    = w_nibble;
                            w_lo_er_nxt  = in_rx_er;
                        end
                    end
                    S_DATA_HI: begin
                        if (!in_rx_dv) begin
                            w_state_nxt  = S_IDLE;
                            w_clk_en_nxt = 1'b1;
                            w_rxd_nxt    = 8'h00;
                            w_dv_nxt     = 1'b0;
                            w_er_nxt     = 1'b0;
                            w_odd_nxt    = 1'b1;
                        end else begin
                            w_state_nxt  = S_DATA_LO;
                            w_clk_en_nxt = 1'b1;
                            w_rxd_nxt    = {w_nibble, r_nib};
                            w_dv_nxt     = 1'b1;
                            w_er_nxt     = r_lo_er | in_rx_er;
                        end
                    end
                    S_DISCARD: begin
                        if (!in_rx_dv) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_nib    <= 4'h0;
            r_pend   <= 1'b0;
            r_lo_er  <= 1'b0;
            r_er_acc <= 1'b0;
            r_clk_en <= 1'b0;
            r_rxd    <= 8'h00;
            r_dv     <= 1'b0;
            r_er     <= 1'b0;
            r_odd    <= 1'b0;
            r_align  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_nib    <= w_nib_nxt;
            r_pend   <= w_pend_nxt;
            r_lo_er  <= w_lo_er_nxt;
            r_er_acc <= w_er_acc_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_rxd    <= w_rxd_nxt;
            r_dv     <= w_dv_nxt;
            r_er     <= w_er_nxt;
            r_odd    <= w_odd_nxt;
            r_align  <= w_align_nxt;
        end
    end

    assign out_clk_en = r_clk_en;
    assign out_rxd    = r_rxd;
    assign out_rx_dv  = r_dv;
    assign out_rx_er  = r_er;
    assign odd_nibble = r_odd;
    assign align_err  = r_align;

`ifdef GMII_RX_PACK_STATS_EN
    localparam logic [STAT_WIDTH-1:0] c_stat_one = STAT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] c_stat_max = '1;

    logic                  w_sfd;
    logic [STAT_WIDTH-1:0] r_frame_count;
    logic [STAT_WIDTH-1:0] r_align_count;

    assign w_sfd = in_clk_en && r_mode && (r_state == S_PRE) && in_rx_dv
                   && (w_nibble == 4'hD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
            r_align_count <= '0;
        end else begin
            if (w_sfd && (r_frame_count != c_stat_max)) begin
                r_frame_count <= r_frame_count + c_stat_one;
            end
            if (w_align_nxt && (r_align_count != c_stat_max)) begin
                r_align_count <= r_align_count + c_stat_one;
            end
        end
    end

    assign frame_count     = r_frame_count;
    assign align_err_count = r_align_count;
`else
    assign frame_count     = '0;
    assign align_err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_nibble_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmii_rx_nibble_pack
// Purpose  : Directed self-checking bench for gmii_rx_nibble_pack. Counters
//            are built 2 bits wide so saturation is reached within the run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gmii_rx_nibble_pack;

    localparam int SW = 2;
`ifdef GMII_RX_PACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mii_select;
    logic          in_clk_en;
    logic [7:0]    in_rxd;
    logic          in_rx_dv;
    logic          in_rx_er;
    logic          out_clk_en;
    logic [7:0]    out_rxd;
    logic          out_rx_dv;
    logic          out_rx_er;
    logic          odd_nibble;
    logic          align_err;
    logic [SW-1:0] frame_count;
    logic [SW-1:0] align_err_count;

    always #5 clk = ~clk;

    gmii_rx_nibble_pack #(.STAT_WIDTH(SW)) dut (
        .clk             (clk),
        .rst             (rst),
        .mii_select      (mii_select),
        .in_clk_en       (in_clk_en),
        .in_rxd          (in_rxd),
        .in_rx_dv        (in_rx_dv),
        .in_rx_er        (in_rx_er),
        .out_clk_en      (out_clk_en),
        .out_rxd         (out_rxd),
        .out_rx_dv       (out_rx_dv),
        .out_rx_er       (out_rx_er),
        .odd_nibble      (odd_nibble),
        .align_err       (align_err),
        .frame_count     (frame_count),
        .align_err_count (align_err_count)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int odd_seen   = 0;
    int align_seen = 0;

    // entry = {odd_nibble, out_rx_er, out_rx_dv, out_rxd}
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (out_clk_en) obs_q.push_back({odd_nibble, out_rx_er, out_rx_dv, out_rxd});
            if (odd_nibble) odd_seen++;
            if (align_err)  align_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ce, input logic [7:0] d, input logic dv, input logic er);
        @(negedge clk);
        in_clk_en = ce;
        in_rxd    = d;
        in_rx_dv  = dv;
        in_rx_er  = er;
    endtask

    // One nibble sample every 10th clock.
    task automatic nib(input logic [3:0] d, input logic dv, input logic er);
        repeat (9) step(1'b0, {4'h0, d}, dv, er);
        step(1'b1, {4'h0, d}, dv, er);
    endtask

    task automatic pre(input int n, input int er_idx);
        for (int i = 0; i < n; i++) nib(4'h5, 1'b1, (i == er_idx));
    endtask

    task automatic end_frame();
        nib(4'h0, 1'b0, 1'b0);
        repeat (12) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic er, input logic dv, input logic odd);
        exp_q.push_back({odd, er, dv, b});
    endtask

    task automatic exp_preamble(input int n55);
        for (int i = 0; i < n55; i++) exp_byte(8'h55, 1'b0, 1'b1, 1'b0);
        exp_byte(8'hD5, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_frame(input string tag);
        check({tag, " count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic int sat(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    initial begin
        rst = 1'b1; mii_select = 1'b0; in_clk_en = 1'b0;
        in_rxd = 8'h00; in_rx_dv = 1'b0; in_rx_er = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_clk_en", out_clk_en, 0);
        check("reset out_rxd",    out_rxd, 0);
        check("reset out_rx_dv",  out_rx_dv, 0);
        check("reset out_rx_er",  out_rx_er, 0);
        check("reset odd_nibble", odd_nibble, 0);
        check("reset align_err",  align_err, 0);
        check("reset frame_count", frame_count, 0);
        check("reset align_err_count", align_err_count, 0);
        rst = 1'b0;

        // ---- byte mode: straight pipeline ----
        for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 8'hD5, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
        exp_preamble(7);
        exp_byte(8'h01, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h02, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check_frame("byte");

        // switch to nibble mode with a clean reset
        mii_select = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- nibble mode, even preamble; SFD latency checked explicitly ----
        pre(14, -1);
        nib(4'hD, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("sfd latency clk_en", out_clk_en, 1);
        check("sfd latency rxd",    out_rxd, 8'hD5);
        nib(4'h1, 1'b1, 1'b0); nib(4'h0, 1'b1, 1'b0);
        nib(4'h2, 1'b1, 1'b0); nib(4'h0, 1'b1, 1'b0);
        end_frame();
        exp_preamble(7);
        exp_byte(8'h01, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h02, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check_frame("even");
        check("even frame_count", frame_count, STATS ? sat(1) : 0);

        // ---- odd preamble, mii_select toggled mid-frame (ignored) ----
        pre(15, -1);
        nib(4'hD, 1'b1, 1'b0);
        mii_select = 1'b0;
        nib(4'h3, 1'b1, 1'b0); nib(4'hA, 1'b1, 1'b0);
        end_frame();
        mii_select = 1'b1;
        exp_preamble(7);
        exp_byte(8'hA3, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check_frame("oddpre");
        check("oddpre align_seen", align_seen, 0);
        check("oddpre frame_count", frame_count, STATS ? sat(2) : 0);

        // ---- odd nibble at end of frame ----
        pre(14, -1);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'h1, 1'b1, 1'b0); nib(4'h0, 1'b1, 1'b0); nib(4'h7, 1'b1, 1'b0);
        end_frame();
        exp_preamble(7);
        exp_byte(8'h01, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h00, 1'b0, 1'b0, 1'b1);
        check_frame("oddend");
        check("oddend odd_seen", odd_seen, 1);
        check("oddend frame_count (saturated)", frame_count, STATS ? sat(3) : 0);

        // ---- alignment error in preamble ----
        pre(2, -1);
        nib(4'h3, 1'b1, 1'b0);
        nib(4'h5, 1'b1, 1'b0); nib(4'hD, 1'b1, 1'b0); nib(4'h1, 1'b1, 1'b0);
        end_frame();
        exp_byte(8'h55, 1'b0, 1'b1, 1'b0);
        check_frame("align");
        check("align align_seen", align_seen, 1);
        check("align align_err_count", align_err_count, STATS ? 1 : 0);

        // ---- bad first nibble ----
        nib(4'hA, 1'b1, 1'b0);
        nib(4'h5, 1'b1, 1'b0); nib(4'hD, 1'b1, 1'b0);
        end_frame();
        check_frame("badfirst");
        check("badfirst align_seen", align_seen, 2);
        check("badfirst align_err_count", align_err_count, STATS ? 2 : 0);

        // ---- good frame after errors ----
        pre(14, -1);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'h4, 1'b1, 1'b0); nib(4'h2, 1'b1, 1'b0);
        end_frame();
        exp_preamble(7);
        exp_byte(8'h24, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check_frame("recover");
        check("recover frame_count", frame_count, STATS ? sat(4) : 0);

        // ---- rx_er in preamble and on a data nibble ----
        pre(14, 2);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'h1, 1'b1, 1'b1); nib(4'h0, 1'b1, 1'b0);
        nib(4'h2, 1'b1, 1'b0); nib(4'h0, 1'b1, 1'b0);
        end_frame();
        exp_byte(8'h55, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h55, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) exp_byte(8'h55, 1'b0, 1'b1, 1'b0);
        exp_byte(8'hD5, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h01, 1'b1, 1'b1, 1'b0);
        exp_byte(8'h02, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check_frame("rxer");

        // ---- asynchronous reset mid-frame ----
        pre(14, -1);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'h1, 1'b1, 1'b0); nib(4'h0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
        exp_preamble(7);
        exp_byte(8'h01, 1'b0, 1'b1, 1'b0);
        check_frame("prerst");
        #2 rst = 1'b1;
        #1;
        check("midrst out_rx_dv", out_rx_dv, 0);
        check("midrst out_rxd",   out_rxd, 0);
        check("midrst out_clk_en", out_clk_en, 0);
        check("midrst frame_count", frame_count, 0);
        check("midrst align_err_count", align_err_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        pre(14, -1);
        nib(4'hD, 1'b1, 1'b0);
        nib(4'h6, 1'b1, 1'b0); nib(4'h9, 1'b1, 1'b0);
        end_frame();
        exp_preamble(7);
        exp_byte(8'h96, 1'b0, 1'b1, 1'b0);
        exp_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check_frame("postrst");
        check("postrst frame_count", frame_count, STATS ? 1 : 0);
        check("total odd_seen", odd_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
